// File: rtl/cl_ddr_scrubber_if.sv
// ============================================================================
// Module      : cl_ddr_scrubber_if
// Description : AXI4 write-channel bundle between the DDR scrubber (master)
//               and the sh_ddr slave port (AW, W and B channels only).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cl_ddr_scrubber_if;
  // AW channel
  logic [5:0]   cl_sh_ddr_awid;
  logic [63:0]  cl_sh_ddr_awaddr;
  logic [7:0]   cl_sh_ddr_awlen;
  logic         cl_sh_ddr_awvalid;
  logic         sh_cl_ddr_awready;
  // W channel
  logic [5:0]   cl_sh_ddr_wid;
  logic [511:0] cl_sh_ddr_wdata;
  logic [63:0]  cl_sh_ddr_wstrb;
  logic         cl_sh_ddr_wlast;
  logic         cl_sh_ddr_wvalid;
  logic         sh_cl_ddr_wready;
  // B channel
  logic [5:0]   sh_cl_ddr_bid;
  logic [1:0]   sh_cl_ddr_bresp;
  logic         sh_cl_ddr_bvalid;
  logic         cl_sh_ddr_bready;

  modport master (
    output cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awvalid,
    input  sh_cl_ddr_awready,
    output cl_sh_ddr_wid, cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
    input  sh_cl_ddr_wready,
    input  sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
    output cl_sh_ddr_bready
  );

  modport slave (
    input  cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awvalid,
    output sh_cl_ddr_awready,
    input  cl_sh_ddr_wid, cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
    output sh_cl_ddr_wready,
    output sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
    input  cl_sh_ddr_bready
  );
endinterface

`default_nettype wire

// File: rtl/cl_ddr_scrubber.sv
// ============================================================================
// Module      : cl_ddr_scrubber
// Description : AXI4 write-only master that zero-fills (or pattern-fills) one
//               DDR4 channel after reset, one burst outstanding at a time.
//               Optional macro SCRB_PATTERN_EN: each 64-bit lane of wdata
//               carries its own byte address instead of zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cl_ddr_scrubber #(
  parameter logic [63:0] MAX_ADDR         = 64'h3FFFFFFFF,
  parameter int          BURST_LEN_MINUS1 = 15,
  parameter logic [5:0]  AXI_ID           = 6'h0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        scrb_enable,
  output logic             scrb_busy,
  output logic             scrb_done,
  output logic             scrb_err,
  output logic [63:0]      scrb_addr,
  input  wire logic        sh_cl_ddr_is_ready,
  cl_ddr_scrubber_if.master ddr
);

  localparam logic [63:0] C_BURST_BYTES = 64'((BURST_LEN_MINUS1 + 1) * 64);
  localparam logic [7:0]  C_LAST_BEAT   = 8'(BURST_LEN_MINUS1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CAL = 3'd1,
    S_BURST    = 3'd2,
    S_RESP     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_en_q;
  logic [7:0]  r_beat;
  logic        r_aw_done;
  logic        r_w_done;
  logic [63:0] r_addr;
  logic        r_err;

  logic        w_start;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_last;
  logic [63:0] w_next_addr;
  logic        w_unused_bid;

  // Single ID in use, so the returned bid carries no information.
  assign w_unused_bid = ^ddr.sh_cl_ddr_bid;

  assign w_start     = scrb_enable & ~r_en_q;
  assign w_aw_hs     = ddr.cl_sh_ddr_awvalid & ddr.sh_cl_ddr_awready;
  assign w_w_hs      = ddr.cl_sh_ddr_wvalid & ddr.sh_cl_ddr_wready;
  assign w_last      = (r_beat == C_LAST_BEAT);
  assign w_next_addr = r_addr + C_BURST_BYTES;

  assign scrb_addr = r_addr;
  assign scrb_err  = r_err;

  assign ddr.cl_sh_ddr_awid   = AXI_ID;
  assign ddr.cl_sh_ddr_awaddr = r_addr;
  assign ddr.cl_sh_ddr_awlen  = C_LAST_BEAT;
  assign ddr.cl_sh_ddr_wid    = AXI_ID;
  assign ddr.cl_sh_ddr_wstrb  = '1;

`ifdef SCRB_PATTERN_EN
  logic [63:0] w_beat_base;
  assign w_beat_base = r_addr + {50'd0, r_beat, 6'd0};
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign ddr.cl_sh_ddr_wdata[64*i +: 64] = w_beat_base + 64'(8 * i);
  end
`else
  assign ddr.cl_sh_ddr_wdata = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and channel valids; AW and W run independently in BURST.
  always_comb begin
    w_state_nxt           = r_state;
    ddr.cl_sh_ddr_awvalid = 1'b0;
    ddr.cl_sh_ddr_wvalid  = 1'b0;
    ddr.cl_sh_ddr_wlast   = 1'b0;
    ddr.cl_sh_ddr_bready  = 1'b0;
    scrb_busy             = 1'b0;
    scrb_done             = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_WAIT_CAL;
      end
      S_WAIT_CAL: begin
        scrb_busy = 1'b1;
        if (sh_cl_ddr_is_ready) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        scrb_busy             = 1'b1;
        ddr.cl_sh_ddr_awvalid = ~r_aw_done;
        ddr.cl_sh_ddr_wvalid  = ~r_w_done;
        ddr.cl_sh_ddr_wlast   = ~r_w_done & w_last;
        if ((r_aw_done | w_aw_hs) && (r_w_done | (w_w_hs & w_last)))
          w_state_nxt = S_RESP;
      end
      S_RESP: begin
        scrb_busy            = 1'b1;
        ddr.cl_sh_ddr_bready = 1'b1;
        if (ddr.sh_cl_ddr_bvalid) begin
          if (w_next_addr > MAX_ADDR) w_state_nxt = S_DONE;
          else if (!scrb_enable)      w_state_nxt = S_IDLE;
          else                        w_state_nxt = S_BURST;
        end
      end
      S_DONE: begin
        scrb_done = 1'b1;
        if (w_start) w_state_nxt = S_WAIT_CAL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Enable edge history, burst bookkeeping, address advance and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_q    <= 1'b0;
      r_beat    <= 8'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= 64'd0;
      r_err     <= 1'b0;
    end else begin
      r_en_q <= scrb_enable;
      if ((r_state == S_IDLE || r_state == S_DONE) && w_start) begin
        r_addr <= 64'd0;
        r_err  <= 1'b0;
      end
      if (r_state == S_RESP && ddr.sh_cl_ddr_bvalid) begin
        r_addr <= w_next_addr;
        if (ddr.sh_cl_ddr_bresp != 2'b00) r_err <= 1'b1;
      end
      if (r_state != S_BURST) begin
        r_beat    <= 8'd0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs) begin
          r_beat <= r_beat + 8'd1;
          if (w_last) r_w_done <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cl_ddr_scrubber.sv
// ============================================================================
// Module      : tb_cl_ddr_scrubber
// Description : Self-checking bench for cl_ddr_scrubber with a randomized
//               AXI slave and an address-list / data reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cl_ddr_scrubber;
  localparam logic [63:0] MAX_ADDR    = 64'h1FFF;
  localparam int          BL1         = 15;
  localparam int          BEATS       = BL1 + 1;
  localparam int          BURST_BYTES = BEATS * 64;
  localparam int          N_BURSTS    = int'((MAX_ADDR + 64'd1) / 64'(BURST_BYTES));
`ifdef SCRB_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scrb_enable = 1'b0;
  logic is_ready = 1'b0;
  logic busy, done, err;
  logic [63:0] addr;

  cl_ddr_scrubber_if ddr();

  cl_ddr_scrubber #(.MAX_ADDR(MAX_ADDR), .BURST_LEN_MINUS1(BL1), .AXI_ID(6'h0)) dut (
    .clk(clk), .rst_n(rst_n), .scrb_enable(scrb_enable), .scrb_busy(busy),
    .scrb_done(done), .scrb_err(err), .scrb_addr(addr),
    .sh_cl_ddr_is_ready(is_ready), .ddr(ddr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave knobs and scoreboard
  bit          bp_en = 1'b0;
  int          err_burst = -1;
  logic [63:0] aw_q[$];
  int          w_beats, w_bursts, b_sent, proto_err, b_delay;
  logic [63:0] pat_capture;
  // Values seen at the previous negedge (what the DUT sampled at the posedge between)
  logic        p_awv, p_awr, p_wv, p_wr, p_wlast, p_bv, p_br;
  logic [63:0] p_awaddr, p_wstrb;
  logic [7:0]  p_awlen;
  logic [5:0]  p_awid, p_wid;
  logic [511:0] p_wdata;

  // Randomized AXI slave plus monitor, all activity on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_q.delete();
      w_beats = 0; w_bursts = 0; b_sent = 0; proto_err = 0; b_delay = 0;
      pat_capture = '0;
      ddr.sh_cl_ddr_awready = 1'b0; ddr.sh_cl_ddr_wready = 1'b0;
      ddr.sh_cl_ddr_bvalid = 1'b0; ddr.sh_cl_ddr_bresp = 2'b00; ddr.sh_cl_ddr_bid = 6'h0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0; p_wlast = 0;
      p_awaddr = '0; p_awlen = '0; p_awid = '0; p_wid = '0; p_wdata = '0; p_wstrb = '0;
    end else begin
      if (p_awv && p_awr) begin
        aw_q.push_back(p_awaddr);
        if (p_awlen !== 8'(BL1) || p_awid !== 6'h0) begin
          proto_err++; $display("monitor: bad awlen/awid %0d/%0d", p_awlen, p_awid);
        end
      end
      if (p_wv && p_wr) begin
        int beat;
        logic [511:0] exp_d;
        beat = w_beats % BEATS;
        for (int i = 0; i < 8; i++)
          exp_d[64*i +: 64] = PAT ? (64'(w_bursts) * 64'(BURST_BYTES) + 64'(beat * 64 + 8 * i)) : 64'd0;
        if (p_wdata !== exp_d) begin
          proto_err++; $display("monitor: wdata lane0 got %h want %h", p_wdata[63:0], exp_d[63:0]);
        end
        if (p_wlast !== (beat == BEATS - 1) || p_wstrb !== '1 || p_wid !== 6'h0) begin
          proto_err++; $display("monitor: wlast/wstrb/wid wrong at beat %0d", beat);
        end
        if (w_bursts == 1 && beat == 3) pat_capture = p_wdata[191:128];
        w_beats++;
        if (beat == BEATS - 1) w_bursts++;
      end
      if (p_bv && p_br) begin
        b_sent++;
        ddr.sh_cl_ddr_bvalid = 1'b0;
        b_delay = bp_en ? int'($urandom_range(0, 20)) : 0;
      end
      if (p_awv && !p_awr && (ddr.cl_sh_ddr_awvalid !== 1'b1 ||
          ddr.cl_sh_ddr_awaddr !== p_awaddr || ddr.cl_sh_ddr_awlen !== p_awlen)) begin
        proto_err++; $display("monitor: AW dropped or changed while stalled");
      end
      if (p_wv && !p_wr && (ddr.cl_sh_ddr_wvalid !== 1'b1 ||
          ddr.cl_sh_ddr_wdata !== p_wdata || ddr.cl_sh_ddr_wlast !== p_wlast)) begin
        proto_err++; $display("monitor: W dropped or changed while stalled");
      end
      ddr.sh_cl_ddr_awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr.sh_cl_ddr_wready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!ddr.sh_cl_ddr_bvalid &&
          ((aw_q.size() < w_bursts) ? aw_q.size() : w_bursts) > b_sent) begin
        if (b_delay == 0) begin
          ddr.sh_cl_ddr_bvalid = 1'b1;
          ddr.sh_cl_ddr_bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
        end else begin
          b_delay--;
        end
      end
      p_awv = ddr.cl_sh_ddr_awvalid; p_awr = ddr.sh_cl_ddr_awready;
      p_awaddr = ddr.cl_sh_ddr_awaddr; p_awlen = ddr.cl_sh_ddr_awlen; p_awid = ddr.cl_sh_ddr_awid;
      p_wv = ddr.cl_sh_ddr_wvalid; p_wr = ddr.sh_cl_ddr_wready; p_wdata = ddr.cl_sh_ddr_wdata;
      p_wlast = ddr.cl_sh_ddr_wlast; p_wstrb = ddr.cl_sh_ddr_wstrb; p_wid = ddr.cl_sh_ddr_wid;
      p_bv = ddr.sh_cl_ddr_bvalid; p_br = ddr.cl_sh_ddr_bready;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    tick(); rst_n = 1'b0; scrb_enable = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin timeout = 1'b0; break; end
    end
  endtask

  // Expected outcome of one full pass from address 0
  task automatic check_full_pass(input string tag, input bit exp_err);
    repeat (5) tick();
    n_checks++;
    if (aw_q.size() !== N_BURSTS) begin
      n_fail++; $display("FAIL %s aw_count got %0d want %0d", tag, aw_q.size(), N_BURSTS);
    end
    for (int k = 0; k < aw_q.size() && k < N_BURSTS; k++) begin
      n_checks++;
      if (aw_q[k] !== 64'(k * BURST_BYTES)) begin
        n_fail++; $display("FAIL %s aw_addr[%0d] got %h want %h", tag, k, aw_q[k], k * BURST_BYTES);
      end
    end
    n_checks++;
    if (w_beats !== N_BURSTS * BEATS || b_sent !== N_BURSTS) begin
      n_fail++; $display("FAIL %s beats/b got %0d/%0d want %0d/%0d", tag, w_beats, b_sent, N_BURSTS * BEATS, N_BURSTS);
    end
    n_checks++;
    if ({done, busy, err} !== {1'b1, 1'b0, exp_err}) begin
      n_fail++; $display("FAIL %s done/busy/err got %b%b%b want 10%b", tag, done, busy, err, exp_err);
    end
    n_checks++;
    if (addr !== MAX_ADDR + 64'd1) begin
      n_fail++; $display("FAIL %s scrb_addr got %h want %h", tag, addr, MAX_ADDR + 64'd1);
    end
    n_checks++;
    if (proto_err !== 0) begin
      n_fail++; $display("FAIL %s protocol_errors got %0d want 0", tag, proto_err);
    end
  endtask

  task automatic test_reset();
    tick(); rst_n = 1'b0; #1;
    n_checks++;
    if ({ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid, ddr.cl_sh_ddr_bready, busy, done, err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000",
        {ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid, ddr.cl_sh_ddr_bready, busy, done, err});
    end
    n_checks++;
    if (addr !== 64'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    apply_reset(); bp_en = 0; err_burst = -1; is_ready = 1'b1;
    scrb_enable = 1'b1;
    tick();
    n_checks++;
    if ({busy, ddr.cl_sh_ddr_awvalid} !== 2'b10) begin
      n_fail++; $display("FAIL basic_lat1 busy/awvalid got %b%b want 10", busy, ddr.cl_sh_ddr_awvalid);
    end
    tick();
    n_checks++;
    if ({ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid} !== 2'b11) begin
      n_fail++; $display("FAIL basic_lat2 aw/wvalid got %b%b want 11", ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid);
    end
    wait_done(3000, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
    check_full_pass("basic", 1'b0);
  endtask

  task automatic test_cal_gating();
    bit to;
    int bad;
    apply_reset(); bp_en = 0; err_burst = -1; is_ready = 1'b0;
    scrb_enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if ({busy, ddr.cl_sh_ddr_awvalid} !== 2'b10) begin
        n_fail++; $display("FAIL cal_wait cyc%0d busy/awvalid got %b%b want 10", i, busy, ddr.cl_sh_ddr_awvalid);
      end
    end
    is_ready = 1'b1;
    tick();
    n_checks++;
    if (ddr.cl_sh_ddr_awvalid !== 1'b1) begin
      n_fail++; $display("FAIL cal_release awvalid got %b want 1", ddr.cl_sh_ddr_awvalid);
    end
    wait_done(3000, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL cal_timeout got 1 want 0"); end
    check_full_pass("cal", 1'b0);
  endtask

  task automatic test_backpressure();
    bit to;
    apply_reset(); bp_en = 1; err_burst = -1; is_ready = 1'b1;
    scrb_enable = 1'b1;
    wait_done(20000, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got 1 want 0"); end
    check_full_pass("bp", 1'b0);
    bp_en = 0;
  endtask

  task automatic test_error();
    bit to;
    apply_reset(); bp_en = 1; err_burst = 2; is_ready = 1'b1;
    scrb_enable = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (b_sent == 2) begin to = 1'b0; break; end
    end
    n_checks++;
    if ({to, err} !== 2'b00) begin
      n_fail++; $display("FAIL err_before timeout/err got %b%b want 00", to, err);
    end
    wait_done(20000, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL err_timeout got 1 want 0"); end
    check_full_pass("err", 1'b1);
    bp_en = 0; err_burst = -1;
  endtask

  task automatic test_abort();
    bit to;
    apply_reset(); bp_en = 0; err_burst = -1; is_ready = 1'b1;
    scrb_enable = 1'b1;
    for (int i = 0; i < 2000 && w_beats < BEATS + 2; i++) tick();
    scrb_enable = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (busy === 1'b0) begin to = 1'b0; break; end
    end
    repeat (5) tick();
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL abort_timeout got 1 want 0"); end
    n_checks++;
    if (aw_q.size() !== 2 || w_beats !== 2 * BEATS || b_sent !== 2) begin
      n_fail++; $display("FAIL abort_counts aw/beats/b got %0d/%0d/%0d want 2/%0d/2", aw_q.size(), w_beats, b_sent, 2 * BEATS);
    end
    n_checks++;
    if ({busy, done, addr} !== {1'b0, 1'b0, 64'(2 * BURST_BYTES)}) begin
      n_fail++; $display("FAIL abort_state busy/done/addr got %b/%b/%h want 0/0/%h", busy, done, addr, 2 * BURST_BYTES);
    end
    // Restart: scoreboard cleared while the DUT is idle
    @(posedge clk); #1;
    aw_q.delete(); w_beats = 0; w_bursts = 0; b_sent = 0;
    tick();
    scrb_enable = 1'b1;
    for (int i = 0; i < 100 && aw_q.size() == 0; i++) tick();
    n_checks++;
    if (aw_q.size() == 0 || aw_q[0] !== 64'd0) begin
      n_fail++; $display("FAIL abort_restart first_aw got %h (n=%0d) want 0", aw_q.size() ? aw_q[0] : 64'hx, aw_q.size());
    end
    wait_done(3000, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL abort_restart_timeout got 1 want 0"); end
    check_full_pass("restart", 1'b0);
  endtask

  task automatic test_pattern_and_async_reset();
    logic [63:0] exp_lane;
    apply_reset(); bp_en = 0; err_burst = -1; is_ready = 1'b1;
    scrb_enable = 1'b1;
    for (int i = 0; i < 2000 && w_beats < BEATS + 6; i++) tick();
    exp_lane = PAT ? 64'h4D0 : 64'h0;
    n_checks++;
    if (pat_capture !== exp_lane) begin
      n_fail++; $display("FAIL pattern_b1_beat3_lane2 got %h want %h", pat_capture, exp_lane);
    end
    n_checks++;
    if (ddr.cl_sh_ddr_wvalid !== 1'b1) begin
      n_fail++; $display("FAIL midburst_wvalid got %b want 1", ddr.cl_sh_ddr_wvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid, busy, addr} !== {3'b000, 64'd0}) begin
      n_fail++; $display("FAIL async_reset aw/w/busy/addr got %b%b%b/%h want 000/0",
        ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid, busy, addr);
    end
    scrb_enable = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cal_gating();
    test_backpressure();
    test_error();
    test_abort();
    test_pattern_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
